// File: rtl/tpu_job_sequencer.sv
// rtl/tpu_job_sequencer.sv - drives one tpuv1 through load A/B, start, compute wait and drain C.
// Optional perf counter on last_job_cycles: define TPU_SEQ_PERF_EN.
module tpu_job_sequencer #(
    parameter int DIM            = 8,
    parameter int ADDRW          = 16,
    parameter int DATAW          = 64,
    parameter int SRC_AW         = 10,
    parameter int COMPUTE_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [SRC_AW-1:0] job_src_base,
    input  logic [SRC_AW-1:0] job_dst_base,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_rd_addr,
    input  logic [DATAW-1:0]  src_rd_data,
    output logic              tpu_r_w,
    output logic [ADDRW-1:0]  tpu_addr,
    output logic [DATAW-1:0]  tpu_dataIn,
    input  logic [DATAW-1:0]  tpu_dataOut,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATAW-1:0]  res_data,
    output logic [SRC_AW-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic [31:0]       last_job_cycles
);

    localparam int CNT_MAX = (COMPUTE_CYCLES > 2*DIM+1) ? COMPUTE_CYCLES : 2*DIM+1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIM_C      = CNT_W'(DIM);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(2*DIM);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*DIM-1);
    localparam logic [CNT_W-1:0] COMP_LAST  = CNT_W'(COMPUTE_CYCLES-1);

    localparam logic [ADDRW-1:0] A_BASE     = ADDRW'('h100);
    localparam logic [ADDRW-1:0] B_BASE     = ADDRW'('h200);
    localparam logic [ADDRW-1:0] C_BASE     = ADDRW'('h300);
    localparam logic [ADDRW-1:0] START_ADDR = ADDRW'('h400);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, k;
    logic [SRC_AW-1:0] src_base_q, src_base_nxt, dst_base_q, dst_base_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            src_base_q <= src_base_nxt;
            dst_base_q <= dst_base_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        src_base_nxt = src_base_q;
        dst_base_nxt = dst_base_q;
        k            = cnt - ONE;
        job_ready    = 1'b0;
        src_rd_en    = 1'b0;
        src_rd_addr  = '0;
        tpu_r_w      = 1'b0;
        tpu_addr     = '0;
        tpu_dataIn   = '0;
        res_valid    = 1'b0;
        res_data     = '0;
        res_addr     = '0;
        done         = 1'b0;
        unique case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    src_base_nxt = job_src_base;
                    dst_base_nxt = job_dst_base;
                    cnt_nxt      = '0;
                    state_nxt    = S_LOAD;
                end
            end
            S_LOAD: begin
                // Read for word cnt overlaps the TPU write of word cnt-1.
                if (cnt != LOAD_LAST) begin
                    src_rd_en   = 1'b1;
                    src_rd_addr = src_base_q + SRC_AW'(cnt);
                end
                if (cnt != '0) begin
                    tpu_r_w    = 1'b1;
                    tpu_dataIn = src_rd_data;
                    tpu_addr   = (k < DIM_C) ? A_BASE + (ADDRW'(k) << 3)
                                             : B_BASE + (ADDRW'(k - DIM_C) << 3);
                end
                if (cnt == LOAD_LAST) begin
                    state_nxt = S_START;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_START: begin
                tpu_r_w   = 1'b1;
                tpu_addr  = START_ADDR;
                cnt_nxt   = '0;
                state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (cnt == COMP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DRAIN;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_DRAIN: begin
                // Each C row is two words: low half at +0, high half at +8.
                tpu_addr  = C_BASE + (ADDRW'(cnt >> 1) << 4) + (ADDRW'(cnt[0]) << 3);
                res_valid = 1'b1;
                res_data  = tpu_dataOut;
                res_addr  = dst_base_q + SRC_AW'(cnt);
                if (res_ready) begin
                    if (cnt == DRAIN_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_cnt, perf_last, perf_inc;

    assign perf_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt  <= '0;
            perf_last <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (job_valid) perf_cnt <= '0;
            end else begin
                perf_cnt <= perf_inc;
            end
            // perf_inc already counts the done cycle itself.
            if (state == S_DONE) perf_last <= perf_inc;
        end
    end

    assign last_job_cycles = perf_last;
`else
    assign last_job_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb/tb_tpu_job_sequencer.sv - scoreboard bench for tpu_job_sequencer with a behavioural tpuv1.
module tb_tpu_job_sequencer;
    localparam int DIM = 8, ADDRW = 16, DATAW = 64, SRC_AW = 10, CC = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid, job_ready;
    logic [SRC_AW-1:0] job_src_base, job_dst_base;
    logic              src_rd_en;
    logic [SRC_AW-1:0] src_rd_addr;
    logic [DATAW-1:0]  src_rd_data;
    logic              tpu_r_w;
    logic [ADDRW-1:0]  tpu_addr;
    logic [DATAW-1:0]  tpu_dataIn, tpu_dataOut;
    logic              res_valid, res_ready;
    logic [DATAW-1:0]  res_data;
    logic [SRC_AW-1:0] res_addr;
    logic              busy, done;
    logic [31:0]       last_job_cycles;

    tpu_job_sequencer #(.DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .SRC_AW(SRC_AW),
                        .COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_src_base(job_src_base), .job_dst_base(job_dst_base),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
        .tpu_dataOut(tpu_dataOut), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_addr(res_addr), .busy(busy), .done(done),
        .last_job_cycles(last_job_cycles)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0, err_cnt = 0, cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Source RAM: one-cycle read latency.
    logic [63:0] mem [0:1023];
    always @(posedge clk) if (src_rd_en) src_rd_data <= mem[src_rd_addr];

    // Behavioural tpuv1: 8-bit A/B elements, 16-bit C elements, four per word.
    logic [63:0] a_m [8], b_m [8], c_m [16];
    always @(posedge clk) begin
        int s;
        if (rst_n && tpu_r_w) begin
            if (tpu_addr >= 16'h100 && tpu_addr < 16'h140)
                a_m[int'(tpu_addr - 16'h100) >> 3] = tpu_dataIn;
            else if (tpu_addr >= 16'h200 && tpu_addr < 16'h240)
                b_m[int'(tpu_addr - 16'h200) >> 3] = tpu_dataIn;
            else if (tpu_addr == 16'h400)
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++) begin
                        s = 0;
                        for (int q = 0; q < 8; q++)
                            s += int'(a_m[i][8*q +: 8]) * int'(b_m[q][8*j +: 8]);
                        c_m[2*i + j/4][16*(j%4) +: 16] = s[15:0];
                    end
        end
    end
    always_comb begin
        tpu_dataOut = 64'h0;
        if (tpu_addr >= 16'h300 && tpu_addr < 16'h380)
            tpu_dataOut = c_m[int'(tpu_addr - 16'h300) >> 3];
    end

    typedef struct packed { logic [9:0] addr; logic [63:0] data; } res_t;
    res_t exp_q [$];

    // A = identity, B row i byte c = seed+i+c+1, so C row i equals B row i widened.
    task automatic setup_job(input logic [9:0] s, input logic [9:0] d, input int seed);
        logic [63:0] brow [8];
        logic [63:0] w;
        res_t r;
        for (int i = 0; i < 8; i++) begin
            mem[s + 10'(i)] = 64'h1 << (8*i);
            for (int c = 0; c < 8; c++) brow[i][8*c +: 8] = 8'(seed + i + c + 1);
            mem[s + 10'(8 + i)] = brow[i];
        end
        for (int j = 0; j < 16; j++) begin
            w = '0;
            for (int e = 0; e < 4; e++) w[16*e +: 16] = {8'h0, brow[j/2][8*(4*(j%2) + e) +: 8]};
            r.addr = d + 10'(j);
            r.data = w;
            exp_q.push_back(r);
        end
    endtask

    function automatic void exp_bus(input int r, input logic [9:0] s, output logic rw,
                                    output logic [15:0] a, output logic [63:0] dat,
                                    output logic en, output logic [9:0] ra);
        int k;
        rw = 0; a = '0; dat = '0; en = 0; ra = '0;
        if (r >= 1 && r <= 16) begin en = 1; ra = s + 10'(r - 1); end
        if (r >= 2 && r <= 17) begin
            k = r - 2;
            rw = 1;
            a = (k < 8) ? 16'h100 + 16'(8*k) : 16'h200 + 16'(8*(k-8));
            dat = mem[s + 10'(k)];
        end
        if (r == 18) begin rw = 1; a = 16'h400; end
    endfunction

    int          acc_cyc, hs_cnt, done_cnt = 0, last_done_cyc = 0, exp_done_rel = 67;
    logic        job_act = 0, stall_prev = 0, perf_pend = 0, b2b_chk = 0;
    logic [9:0]  cur_src, held_addr;
    logic [63:0] held_data;
    logic [31:0] exp_perf;

    always @(negedge clk) begin
        int rel;
        logic e_rw, e_en;
        logic [15:0] e_a;
        logic [63:0] e_d;
        logic [9:0] e_ra;
        res_t got;
        if (!rst_n) begin
            job_act = 0;
            stall_prev = 0;
        end else begin
            if (perf_pend) begin
                chk("last_job_cycles", 64'(last_job_cycles), 64'(exp_perf));
                perf_pend = 0;
            end
            if (!job_act) chk("idle_quiet", {60'h0, busy, done, res_valid, tpu_r_w}, 64'h0);
            if (job_act) begin
                rel = cyc - acc_cyc + 1;
                if (rel <= 50) begin
                    exp_bus(rel, cur_src, e_rw, e_a, e_d, e_en, e_ra);
                    chk("tpu_r_w", 64'(tpu_r_w), 64'(e_rw));
                    chk("tpu_addr", 64'(tpu_addr), 64'(e_a));
                    chk("src_rd", {53'h0, src_rd_en, src_rd_addr}, {53'h0, e_en, e_ra});
                    if (e_rw) chk("tpu_dataIn", tpu_dataIn, e_d);
                end
                if (res_valid) begin
                    chk("drain_read", 64'(tpu_r_w), 64'h0);
                    if (stall_prev) chk("held_res", {res_addr, res_data[53:0]}, {held_addr, held_data[53:0]});
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("res_unexpected", 64'(res_addr), 64'h3FF_FFFF);
                        end else begin
                            got = exp_q.pop_front();
                            chk("res_addr", 64'(res_addr), 64'(got.addr));
                            chk("res_data", res_data, got.data);
                        end
                        hs_cnt++;
                    end
                    stall_prev = !res_ready;
                    held_addr  = res_addr;
                    held_data  = res_data;
                end
                if (done) begin
                    chk("done_cycle", 64'(rel), 64'(exp_done_rel));
                    chk("res_count", 64'(hs_cnt), 64'd16);
                    job_act = 0;
                    done_cnt++;
                    last_done_cyc = cyc;
                    perf_pend = 1;
`ifdef TPU_SEQ_PERF_EN
                    exp_perf = 32'(exp_done_rel);
`else
                    exp_perf = 32'h0;
`endif
                end
            end
            if (job_valid && job_ready) begin
                if (b2b_chk) chk("b2b_accept", 64'(cyc), 64'(last_done_cyc + 1));
                job_act    = 1;
                acc_cyc    = cyc + 1;
                hs_cnt     = 0;
                stall_prev = 0;
                cur_src    = job_src_base;
            end
        end
    end

    task automatic start_job(input logic [9:0] s, input logic [9:0] d);
        @(negedge clk);
        job_src_base = s;
        job_dst_base = d;
        job_valid = 1;
        @(posedge clk);
        #1 job_valid = 0;
    endtask

    task automatic wait_done(input int target);
        int t;
        for (t = 0; t < 400 && done_cnt < target; t++) @(posedge clk);
        if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic stall_at(input int at);
        int t = 0;
        while (hs_cnt != at && t < 300) begin
            @(posedge clk);
            #1 t++;
        end
        if (hs_cnt != at) chk("stall_timeout", 64'(hs_cnt), 64'(at));
        res_ready = 0;
        repeat (5) @(posedge clk);
        #1 res_ready = 1;
    endtask

    task automatic reset_state(input string tag);
        chk({tag, "_job_ready"}, 64'(job_ready), 64'h1);
        chk({tag, "_outs"}, {58'h0, busy, done, res_valid, tpu_r_w, src_rd_en, |tpu_addr}, 64'h0);
        chk({tag, "_perf"}, 64'(last_job_cycles), 64'h0);
    endtask

    initial begin
        int base;
        rst_n = 0; job_valid = 0; job_src_base = '0; job_dst_base = '0; res_ready = 1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 reset_state("reset");
        @(negedge clk) rst_n = 1;

        // Basic job and bus trace.
        setup_job(10'h010, 10'h080, 0);
        exp_done_rel = 67;
        base = done_cnt;
        start_job(10'h010, 10'h080);
        wait_done(base + 1);

        // Backpressure on j=3 and j=15.
        setup_job(10'h100, 10'h200, 5);
        exp_done_rel = 77;
        base = done_cnt;
        start_job(10'h100, 10'h200);
        stall_at(3);
        stall_at(15);
        wait_done(base + 1);

        // Address wrap on both source and destination.
        setup_job(10'h3FC, 10'h3FA, 9);
        exp_done_rel = 67;
        base = done_cnt;
        start_job(10'h3FC, 10'h3FA);
        wait_done(base + 1);

        // job_valid held through a job with changing bases.
        setup_job(10'h040, 10'h0C0, 17);
        setup_job(10'h060, 10'h0E0, 33);
        base = done_cnt;
        @(negedge clk);
        job_src_base = 10'h040; job_dst_base = 10'h0C0; job_valid = 1;
        @(posedge clk);
        #1 job_src_base = 10'h060; job_dst_base = 10'h0E0;
        b2b_chk = 1;
        wait_done(base + 1);
        @(posedge clk);
        #1 job_valid = 0;
        wait_done(base + 2);
        b2b_chk = 0;

        // Reset in the middle of COMPUTE, then a clean job.
        setup_job(10'h180, 10'h280, 40);
        start_job(10'h180, 10'h280);
        repeat (29) @(posedge clk);
        #2 rst_n = 0;
        #1 reset_state("abort");
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        setup_job(10'h1A0, 10'h2A0, 50);
        base = done_cnt;
        start_job(10'h1A0, 10'h2A0);
        wait_done(base + 1);

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
